// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the program loader.
//   rx_valid/rx_data/rx_ready : incoming program bytes (valid/ready handshake)
//   imem_we/imem_addr/imem_wdata : word writes into the core's instruction memory
// master: loader side (consumes bytes, drives memory writes).
// slave : environment side (produces bytes, observes memory writes).
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: packs a little-endian byte stream into 32-bit words, writes them to
// instruction memory from address 0, verifies a trailing checksum byte and holds the core
// in reset until a clean load completes.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-low reset
//   start_i   : begin a load (sampled only in idle)
//   len_i     : number of words, legal range 1..2**ADDR_W
//   abort_i   : synchronous abort of a load in progress
//   bus_io    : byte stream in, instruction-memory writes out
//   cpu_rst_o : active-high reset to the core
//   busy_o    : loader not idle
//   done_o    : one-cycle pulse, load finished (good or bad)
//   err_o     : one-cycle pulse, load failed / rejected / aborted
module imem_loader #(
  parameter int unsigned ADDR_W        = 8,
  parameter bit          HOLD_ON_RESET = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              abort_i,
  imem_loader_if.master     bus_io,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StCsum,
    StDone
  } state_e;

  localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LenOne = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        sum_q, sum_d;
  logic              bad_q, bad_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              xfer;
  logic              len_legal;
  logic              last_word;
  logic [7:0]        sum_next;

  assign xfer      = bus_io.rx_valid & rx_ready_q;
  assign len_legal = (len_i != '0) && (len_i <= MaxLen);
  assign last_word = ({1'b0, addr_q} == (len_q - LenOne));
  assign sum_next  = sum_q + bus_io.rx_data;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    sum_d      = sum_q;
    bad_d      = bad_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (len_legal) begin
            len_d      = len_i;
            addr_d     = '0;
            byte_cnt_d = '0;
            sum_d      = '0;
            bad_d      = 1'b0;
            cpu_rst_d  = 1'b1;
            state_d    = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StLoad: begin
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (xfer) begin
          sum_d = sum_next;
          if (byte_cnt_q == 2'd3) begin
            // Final byte goes straight into the write register, so the word is only
            // ever exposed on the bus once complete.
            we_d       = 1'b1;
            waddr_d    = addr_q;
            wdata_d    = {bus_io.rx_data, word_q};
            byte_cnt_d = '0;
            state_d    = StWrite;
          end else begin
            unique case (byte_cnt_q)
              2'd0:    word_d[7:0]   = bus_io.rx_data;
              2'd1:    word_d[15:8]  = bus_io.rx_data;
              default: word_d[23:16] = bus_io.rx_data;
            endcase
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      StWrite: begin
        // The strobe for this cycle is already registered; abort only skips what follows.
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (last_word) begin
          state_d = StCsum;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StLoad;
        end
      end

      StCsum: begin
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (xfer) begin
          bad_d   = (sum_next != 8'h00);
          done_d  = 1'b1;
          err_d   = bad_d;
          state_d = StDone;
        end
      end

      StDone: begin
        if (!bad_q) begin
          cpu_rst_d = 1'b0;
        end
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    rx_ready_d = (state_d == StLoad) || (state_d == StCsum);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      len_q      <= '0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      sum_q      <= '0;
      bad_q      <= 1'b0;
      cpu_rst_q  <= HOLD_ON_RESET;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      sum_q      <= sum_d;
      bad_q      <= bad_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus_io.rx_ready   = rx_ready_q;
  assign bus_io.imem_we    = we_q;
  assign bus_io.imem_addr  = waddr_q;
  assign bus_io.imem_wdata = wdata_q;
  assign cpu_rst_o         = cpu_rst_q;
  assign busy_o            = (state_q != StIdle);
  assign done_o            = done_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes and load results are queued when
// stimulus is driven and popped by monitors when the loader produces them.
module tb_imem_loader;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   len_in;
  logic          abort;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [AW+31:0] wr_q[$];
  logic           res_q[$];
  logic [31:0]    words[$];
  logic [AW+31:0] exp_wr;
  logic           exp_res;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(
    .ADDR_W       (AW),
    .HOLD_ON_RESET(1'b1)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .start_i  (start),
    .len_i    (len_in),
    .abort_i  (abort),
    .bus_io   (bus),
    .cpu_rst_o(cpu_rst),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write and done monitors
  always @(negedge clk) begin
    if (bus.imem_we) begin
      checks++;
      assert (wr_q.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_write observed=%h_%h expected=no write",
               bus.imem_addr, bus.imem_wdata);
      end
      if (wr_q.size() != 0) begin
        exp_wr = wr_q.pop_front();
        chk("imem_write", {24'd0, bus.imem_addr, bus.imem_wdata}, {24'd0, exp_wr});
      end
    end
    if (done) begin
      checks++;
      assert (res_q.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_done observed=1 expected=0");
      end
      if (res_q.size() != 0) begin
        exp_res = res_q.pop_front();
        chk("done_err", 64'(err), 64'(exp_res));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] csum_of();
    logic [7:0] s = 8'h00;
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) s = s + words[i][8*k +: 8];
    end
    return 8'h00 - s;
  endfunction

  task automatic do_start(input int n);
    start  = 1'b1;
    len_in = (AW+1)'(n);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Sends one byte after `gap` idle cycles; optionally pokes start_i during the gap.
  task automatic xfer(input logic [7:0] b, input int gap, input bit poke);
    int n;
    bus.rx_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      if (poke && g == 0) begin
        start  = 1'b1;
        len_in = (AW+1)'(5);
      end
      @(posedge clk);
      #1 start = 1'b0;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    @(negedge clk);
    while (!bus.rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("rx_ready_timeout", 64'(bus.rx_ready), 64'd1);
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic run_load(input int gap, input bit poke, input logic [7:0] csum,
                          input bit exp_bad);
    foreach (words[i]) wr_q.push_back({i[AW-1:0], words[i]});
    res_q.push_back(exp_bad);
    do_start(words.size());
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("cpu_rst_in_load", 64'(cpu_rst), 64'd1);
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) xfer(words[i][8*k +: 8], gap, poke && i == 1 && k == 0);
    end
    xfer(csum, gap, 1'b0);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd1);
    chk("cpu_rst_during_done", 64'(cpu_rst), 64'd1);
    @(posedge clk);
    #1;
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("cpu_rst_after_load", 64'(cpu_rst), 64'(exp_bad));
    chk("writes_drained", 64'(wr_q.size()), 64'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    len_in       = '0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    chk("rst_we", 64'(bus.imem_we), 64'd0);
    chk("rst_done_err", {62'd0, done, err}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: clean two-word load
    words = '{32'h0000_0013, 32'h0010_0093};
    run_load(0, 1'b0, 8'h4A, 1'b0);

    // 2: same program, wrong checksum
    run_load(0, 1'b0, 8'h00, 1'b1);

    // 3: illegal lengths rejected
    do_start(0);
    chk("len0_err", 64'(err), 64'd1);
    chk("len0_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 chk("len0_err_one_cycle", 64'(err), 64'd0);
    do_start(257);
    chk("len257_err", 64'(err), 64'd1);
    chk("len257_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // 4: valid gaps and a stray start during load
    run_load(3, 1'b1, 8'h4A, 1'b0);

    // 5: async reset mid-load, only the complete word is written
    wr_q.push_back({8'd0, 32'h0000_0013});
    do_start(2);
    for (int k = 0; k < 4; k++) xfer(words[0][8*k +: 8], 0, 1'b0);
    xfer(words[1][7:0], 0, 1'b0);
    xfer(words[1][15:8], 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    chk("mid_rst_we", 64'(bus.imem_we), 64'd0);
    chk("mid_rst_bus", {24'd0, bus.imem_addr, bus.imem_wdata}, 64'd0);
    chk("mid_rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("mid_rst_writes", 64'(wr_q.size()), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    words = '{32'hDEAD_BEEF};
    run_load(0, 1'b0, csum_of(), 1'b0);

    // 6: full-depth load, then aborts
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back($urandom);
    run_load(0, 1'b0, csum_of(), 1'b0);
    chk("last_addr_hold", 64'(bus.imem_addr), 64'hFF);
    chk("last_data_hold", 64'(bus.imem_wdata), 64'(words[255]));

    // abort in WRITE: that write still lands
    words = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    wr_q.push_back({8'd0, words[0]});
    do_start(4);
    for (int k = 0; k < 4; k++) xfer(words[0][8*k +: 8], 0, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_write_err", 64'(err), 64'd1);
    chk("abort_write_busy", 64'(busy), 64'd0);
    chk("abort_write_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("abort_write_drained", 64'(wr_q.size()), 64'd0);

    // abort in LOAD: partial word discarded
    do_start(2);
    xfer(8'hAA, 0, 1'b0);
    xfer(8'hBB, 0, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_load_err", 64'(err), 64'd1);
    chk("abort_load_busy", 64'(busy), 64'd0);

    // abort in IDLE is ignored
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_idle_err", 64'(err), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("final_writes_left", 64'(wr_q.size()), 64'd0);
    chk("final_results_left", 64'(res_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
